time_entry_register: RTL and testbench

TIME_ENTRY_REGISTER -- requirements
Module: time_entry_register

---
 rtl/time_entry_register_if.sv | 29 ++
 rtl/time_entry_register.sv | 128 ++++++++++++
 tb/tb_time_entry_register.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/time_entry_register_if.sv
// Keypad-side inputs and digit-buffer/timer-handshake outputs of the time entry register.
// The bench drives through master; the register sits on slave.
interface time_entry_register_if;
  logic [3:0] bcd;
  logic       loadn;
  logic       clear_key;
  logic       start;
  logic       timer_ready;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [2:0] digit_count;
  logic       load_valid;
  logic       entry_err;
  logic       busy;

  modport master (
    output bcd, loadn, clear_key, start, timer_ready,
    input  sec_ones, sec_tens, min_ones, min_tens, digit_count,
           load_valid, entry_err, busy
  );

  modport slave (
    input  bcd, loadn, clear_key, start, timer_ready,
    output sec_ones, sec_tens, min_ones, min_tens, digit_count,
           load_valid, entry_err, busy
  );
endinterface

// File: rtl/time_entry_register.sv
// Collects up to four BCD keypad digits as MM:SS and offers them to a downstream
// timer through a valid/ready load handshake; all outputs come straight from registers.
module time_entry_register (
  input  logic                 clk,
  input  logic                 reset,
  time_entry_register_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ENTRY, LOAD} state_t;

  state_t     r_state;
  logic       r_loadn_prev;
  logic       r_loadn_seen;
  logic       r_press_p0;
  logic [3:0] r_bcd_p0;
  logic [3:0] r_sec_ones;
  logic [3:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [3:0] r_min_tens;
  logic [2:0] r_count;
  logic       r_load_valid;
  logic       r_entry_err;
  logic       r_busy;

  logic       w_fall;
  logic       w_digit_ok;
  logic       w_start_ok;

  // r_loadn_seen blocks a key held low across reset release from looking like a fresh press.
  assign w_fall     = r_loadn_seen & r_loadn_prev & ~bus.loadn;
  assign w_digit_ok = r_press_p0 & (r_bcd_p0 <= 4'd9) & (r_count < 3'd4);
  assign w_start_ok = (r_sec_tens <= 4'd5);

  // Stage p0: edge detect and digit capture; stage p1: FSM and digit buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_loadn_prev <= 1'b1;
      r_loadn_seen <= 1'b0;
      r_press_p0   <= 1'b0;
      r_bcd_p0     <= 4'd0;
      r_sec_ones   <= 4'd0;
      r_sec_tens   <= 4'd0;
      r_min_ones   <= 4'd0;
      r_min_tens   <= 4'd0;
      r_count      <= 3'd0;
      r_load_valid <= 1'b0;
      r_entry_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_loadn_prev <= bus.loadn;
      r_loadn_seen <= r_loadn_seen | bus.loadn;
      r_press_p0   <= w_fall;
      r_bcd_p0     <= bus.bcd;
      r_entry_err  <= 1'b0;

      if (bus.clear_key) begin
        r_state      <= IDLE;
        r_sec_ones   <= 4'd0;
        r_sec_tens   <= 4'd0;
        r_min_ones   <= 4'd0;
        r_min_tens   <= 4'd0;
        r_count      <= 3'd0;
        r_load_valid <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_digit_ok) begin
              r_min_tens <= r_min_ones;
              r_min_ones <= r_sec_tens;
              r_sec_tens <= r_sec_ones;
              r_sec_ones <= r_bcd_p0;
              r_count    <= r_count + 3'd1;
              r_state    <= ENTRY;
              r_busy     <= 1'b1;
            end
          end

          ENTRY: begin
            // A start, honoured or rejected, swallows any press landing in the same cycle.
            if (bus.start) begin
              if (w_start_ok) begin
                r_state      <= LOAD;
                r_load_valid <= 1'b1;
              end else begin
                r_entry_err  <= 1'b1;
              end
            end else if (w_digit_ok) begin
              r_min_tens <= r_min_ones;
              r_min_ones <= r_sec_tens;
              r_sec_tens <= r_sec_ones;
              r_sec_ones <= r_bcd_p0;
              r_count    <= r_count + 3'd1;
            end
          end

          LOAD: begin
            if (r_load_valid && bus.timer_ready) begin
              r_state      <= IDLE;
              r_sec_ones   <= 4'd0;
              r_sec_tens   <= 4'd0;
              r_min_ones   <= 4'd0;
              r_min_tens   <= 4'd0;
              r_count      <= 3'd0;
              r_load_valid <= 1'b0;
              r_busy       <= 1'b0;
            end
          end

          default: begin
            r_state      <= IDLE;
            r_load_valid <= 1'b0;
            r_busy       <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sec_ones    = r_sec_ones;
  assign bus.sec_tens    = r_sec_tens;
  assign bus.min_ones    = r_min_ones;
  assign bus.min_tens    = r_min_tens;
  assign bus.digit_count = r_count;
  assign bus.load_valid  = r_load_valid;
  assign bus.entry_err   = r_entry_err;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_time_entry_register.sv
// Directed bench for time_entry_register: a key-press vector table followed by
// hand-written sequences for start rejection, load handshake, clear and reset.
module tb_time_entry_register;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  time_entry_register_if bus ();

  time_entry_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr_before;
    logic [3:0]  key;
    logic [15:0] exp_buf;
    logic [2:0]  exp_cnt;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] buf_now();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  endfunction

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] d);
    bus.bcd   = d;
    bus.loadn = 1'b0;
    tick(3);
    bus.loadn = 1'b1;
    tick(2);
  endtask

  task automatic do_clear();
    bus.clear_key = 1'b1;
    tick(1);
    bus.clear_key = 1'b0;
    tick(1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  initial begin
    int n_lv;

    bus.bcd = 4'd0;
    bus.loadn = 1'b1;
    bus.clear_key = 1'b0;
    bus.start = 1'b0;
    bus.timer_ready = 1'b0;

    vecs[0] = '{1'b1, 4'd1,  16'h0001, 3'd1, 1'b1};
    vecs[1] = '{1'b0, 4'd2,  16'h0012, 3'd2, 1'b1};
    vecs[2] = '{1'b0, 4'd3,  16'h0123, 3'd3, 1'b1};
    vecs[3] = '{1'b0, 4'd0,  16'h1230, 3'd4, 1'b1};
    vecs[4] = '{1'b0, 4'd7,  16'h1230, 3'd4, 1'b1};
    vecs[5] = '{1'b0, 4'd12, 16'h1230, 3'd4, 1'b1};
    vecs[6] = '{1'b1, 4'd10, 16'h0000, 3'd0, 1'b0};
    vecs[7] = '{1'b0, 4'd9,  16'h0009, 3'd1, 1'b1};

    tick(3);
    reset = 1'b0;
    tick(1);
    chk("reset_buf",   32'(buf_now()),        32'h0);
    chk("reset_cnt",   32'(bus.digit_count),  32'd0);
    chk("reset_lv",    32'(bus.load_valid),   32'd0);
    chk("reset_err",   32'(bus.entry_err),    32'd0);
    chk("reset_busy",  32'(bus.busy),         32'd0);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].clr_before) do_clear();
      press(vecs[i].key);
      chk($sformatf("vec%0d_buf", i),  32'(buf_now()),       32'(vecs[i].exp_buf));
      chk($sformatf("vec%0d_cnt", i),  32'(bus.digit_count), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy),        32'(vecs[i].exp_busy));
    end

    // start in IDLE is ignored
    do_clear();
    pulse_start();
    chk("idle_start_err",  32'(bus.entry_err),  32'd0);
    chk("idle_start_lv",   32'(bus.load_valid), 32'd0);
    chk("idle_start_busy", 32'(bus.busy),       32'd0);

    // rejected start: seconds tens digit 7
    press(4'd0); press(4'd0); press(4'd7); press(4'd5);
    chk("rej_buf_before", 32'(buf_now()), 32'h0075);
    pulse_start();
    chk("rej_err_pulse", 32'(bus.entry_err),  32'd1);
    chk("rej_lv",        32'(bus.load_valid), 32'd0);
    chk("rej_busy",      32'(bus.busy),       32'd1);
    tick(1);
    chk("rej_err_drop",  32'(bus.entry_err),  32'd0);
    chk("rej_lv_after",  32'(bus.load_valid), 32'd0);
    chk("rej_buf_after", 32'(buf_now()),      32'h0075);
    chk("rej_cnt_after", 32'(bus.digit_count), 32'd4);

    // accepted load with stalled ready
    do_clear();
    press(4'd0); press(4'd1); press(4'd3); press(4'd0);
    bus.timer_ready = 1'b1;
    tick(1);
    bus.timer_ready = 1'b0;
    chk("ready_outside_load_busy", 32'(bus.busy),       32'd1);
    chk("ready_outside_load_lv",   32'(bus.load_valid), 32'd0);
    chk("ready_outside_load_buf",  32'(buf_now()),      32'h0130);
    pulse_start();
    n_lv = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.load_valid) n_lv++;
      chk($sformatf("load_hold_buf%0d", i), 32'(buf_now()), 32'h0130);
      bus.timer_ready = (i == 5);
      tick(1);
    end
    bus.timer_ready = 1'b0;
    chk("load_lv_cycles", 32'(n_lv),            32'd6);
    chk("xfer_lv",        32'(bus.load_valid),  32'd0);
    chk("xfer_buf",       32'(buf_now()),       32'h0);
    chk("xfer_cnt",       32'(bus.digit_count), 32'd0);
    chk("xfer_busy",      32'(bus.busy),        32'd0);

    // press ignored during LOAD, then clear aborts despite ready
    press(4'd0); press(4'd1); press(4'd3); press(4'd0);
    pulse_start();
    chk("abort_lv_up", 32'(bus.load_valid), 32'd1);
    press(4'd5);
    chk("load_press_buf", 32'(buf_now()),       32'h0130);
    chk("load_press_lv",  32'(bus.load_valid),  32'd1);
    bus.clear_key = 1'b1;
    bus.timer_ready = 1'b1;
    tick(1);
    bus.clear_key = 1'b0;
    bus.timer_ready = 1'b0;
    chk("abort_lv",   32'(bus.load_valid),  32'd0);
    chk("abort_buf",  32'(buf_now()),       32'h0);
    chk("abort_cnt",  32'(bus.digit_count), 32'd0);
    chk("abort_busy", 32'(bus.busy),        32'd0);

    // reset mid-entry with the key held low through release
    press(4'd4); press(4'd2);
    chk("pre_reset_cnt", 32'(bus.digit_count), 32'd2);
    bus.bcd = 4'd6;
    bus.loadn = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(4);
    chk("held_cnt",  32'(bus.digit_count), 32'd0);
    chk("held_buf",  32'(buf_now()),       32'h0);
    chk("held_busy", 32'(bus.busy),        32'd0);
    chk("held_lv",   32'(bus.load_valid),  32'd0);
    bus.loadn = 1'b1;
    tick(2);
    chk("release_cnt", 32'(bus.digit_count), 32'd0);
    press(4'd8);
    chk("next_press_cnt", 32'(bus.digit_count), 32'd1);
    chk("next_press_buf", 32'(buf_now()),       32'h0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
